rotate_output_scheduler: RTL and testbench

Sequences one rotated frame out of the source frame buffer and drives the pixel and handshake inputs of the output formatting stage. It computes a per-pixel read address for rotations of 0/90/180/270 degrees and issues buffer reads in raster order of the rotated image. It aligns data with valid, line-end and frame-start flags, and inserts programmable horizontal blanking. It sits between the frame buffer read port and the output interface.

---
 rtl/rotate_output_scheduler_if.sv | 32 +++
 rtl/rotate_output_scheduler.sv | 153 +++++++++++++++
 tb/tb_rotate_output_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotate_output_scheduler_if.sv
// Handshake and data bundle between the rotate scheduler, the frame buffer
// read port and the output formatting stage.
interface rotate_output_scheduler_if #(
  parameter int AW    = 20,
  parameter int DIM_W = 12
);
  logic             frame_start;
  logic [DIM_W-1:0] src_width;
  logic [DIM_W-1:0] src_height;
  logic [1:0]       rot_mode;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [23:0]      rd_data;
  logic             out_pixel_ready;
  logic             out_pixel_valid;
  logic             out_line_end;
  logic [23:0]      out_pixel_data;
  logic             busy;
  logic             frame_done;

  modport master (
    input  frame_start, src_width, src_height, rot_mode, rd_data,
    output rd_en, rd_addr, out_pixel_ready, out_pixel_valid, out_line_end,
           out_pixel_data, busy, frame_done
  );

  modport slave (
    output frame_start, src_width, src_height, rot_mode, rd_data,
    input  rd_en, rd_addr, out_pixel_ready, out_pixel_valid, out_line_end,
           out_pixel_data, busy, frame_done
  );
endinterface

// File: rtl/rotate_output_scheduler.sv
// Walks the rotated output raster, issues one frame buffer read per pixel and
// aligns the returned data with valid, line-end and frame-start flags.
module rotate_output_scheduler #(
  parameter int AW     = 20,
  parameter int DIM_W  = 12,
  parameter int HBLANK = 4
) (
  input  logic                          Clk_in,
  input  logic                          Rst_n,
  rotate_output_scheduler_if.master     bus
);

  localparam int               HW    = (HBLANK < 2) ? 1 : $clog2(HBLANK);
  localparam logic [DIM_W-1:0] D_ONE = DIM_W'(1);
  localparam logic [AW-1:0]    A_ONE = AW'(1);
  localparam logic [HW-1:0]    H_ONE = HW'(1);

  typedef enum logic [2:0] {IDLE, START, LINE, HBLK, FLUSH, DONE} state_t;

  state_t           state;
  logic [DIM_W-1:0] w, h, wo, ho;
  logic [DIM_W-1:0] cx, cy;
  logic [1:0]       mode;
  logic [HW-1:0]    hcnt;

  logic [DIM_W-1:0] in_wo, in_ho;
  logic             at_eol, last_line;

  // cx/cy always name the pixel whose read is on rd_addr
  assign in_wo     = bus.rot_mode[0] ? bus.src_height : bus.src_width;
  assign in_ho     = bus.rot_mode[0] ? bus.src_width  : bus.src_height;
  assign at_eol    = (cx == wo - D_ONE);
  assign last_line = (cy == ho - D_ONE);

  assign bus.out_pixel_data = bus.out_pixel_valid ? bus.rd_data : '0;

  function automatic logic [AW-1:0] src_addr(
    input logic [DIM_W-1:0] xc,
    input logic [DIM_W-1:0] yc,
    input logic [DIM_W-1:0] wd,
    input logic [DIM_W-1:0] ht,
    input logic [1:0]       md
  );
    logic [AW-1:0] xa, ya, wa, ha;
    xa = AW'(xc);
    ya = AW'(yc);
    wa = AW'(wd);
    ha = AW'(ht);
    case (md)
      2'd0:    src_addr = ya * wa + xa;
      2'd1:    src_addr = (ha - A_ONE - xa) * wa + ya;
      2'd2:    src_addr = (ha - A_ONE - ya) * wa + (wa - A_ONE - xa);
      default: src_addr = xa * wa + (wa - A_ONE - ya);
    endcase
  endfunction

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      state               <= IDLE;
      w                   <= '0;
      h                   <= '0;
      wo                  <= '0;
      ho                  <= '0;
      cx                  <= '0;
      cy                  <= '0;
      mode                <= '0;
      hcnt                <= '0;
      bus.rd_en           <= 1'b0;
      bus.rd_addr         <= '0;
      bus.out_pixel_ready <= 1'b0;
      bus.out_pixel_valid <= 1'b0;
      bus.out_line_end    <= 1'b0;
      bus.busy            <= 1'b0;
      bus.frame_done      <= 1'b0;
    end else begin
      bus.out_pixel_valid <= bus.rd_en;
      bus.out_line_end    <= bus.rd_en & at_eol;
      bus.out_pixel_ready <= 1'b0;
      bus.rd_en           <= 1'b0;
      bus.frame_done      <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.frame_start) begin
            w        <= bus.src_width;
            h        <= bus.src_height;
            mode     <= bus.rot_mode;
            wo       <= in_wo;
            ho       <= in_ho;
            cx       <= '0;
            cy       <= '0;
            bus.busy <= 1'b1;
            if (bus.src_width == '0 || bus.src_height == '0) begin
              state          <= DONE;
              bus.frame_done <= 1'b1;
            end else begin
              state               <= START;
              bus.out_pixel_ready <= 1'b1;
              bus.rd_en           <= 1'b1;
              bus.rd_addr         <= src_addr('0, '0, bus.src_width,
                                              bus.src_height, bus.rot_mode);
            end
          end
        end

        START, LINE: begin
          if (!at_eol) begin
            state       <= LINE;
            cx          <= cx + D_ONE;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= src_addr(cx + D_ONE, cy, w, h, mode);
          end else if (!last_line) begin
            cx <= '0;
            cy <= cy + D_ONE;
            if (HBLANK == 0) begin
              state       <= LINE;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= src_addr('0, cy + D_ONE, w, h, mode);
            end else begin
              state <= HBLK;
              hcnt  <= HW'(HBLANK - 1);
            end
          end else begin
            state <= FLUSH;
          end
        end

        HBLK: begin
          if (hcnt == '0) begin
            state       <= LINE;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= src_addr(cx, cy, w, h, mode);
          end else begin
            hcnt <= hcnt - H_ONE;
          end
        end

        FLUSH: begin
          state          <= DONE;
          bus.frame_done <= 1'b1;
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_output_scheduler.sv
// Self-checking bench: two schedulers (HBLANK 0 and 4) run side by side and
// every cycle is compared against a raster-level reference model.
module tb_rotate_output_scheduler;
  localparam int AW    = 20;
  localparam int DIM_W = 12;
  localparam int MAXC  = 80;

  typedef struct packed {
    logic          ready;
    logic          en;
    logic [AW-1:0] addr;
    logic          valid;
    logic          le;
    logic [23:0]   data;
    logic          done;
    logic          busy;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotate_output_scheduler_if #(.AW(AW), .DIM_W(DIM_W)) bus0 ();
  rotate_output_scheduler_if #(.AW(AW), .DIM_W(DIM_W)) bus4 ();

  rotate_output_scheduler #(.AW(AW), .DIM_W(DIM_W), .HBLANK(0)) dut0 (
    .Clk_in(clk), .Rst_n(rst_n), .bus(bus0.master));
  rotate_output_scheduler #(.AW(AW), .DIM_W(DIM_W), .HBLANK(4)) dut4 (
    .Clk_in(clk), .Rst_n(rst_n), .bus(bus4.master));

  // buffer word i holds i; non-read cycles return junk so ungated data shows
  always @(posedge clk) begin
    bus0.rd_data <= bus0.rd_en ? {4'h0, bus0.rd_addr} : (24'h5A0000 | 24'($urandom_range(1, 65535)));
    bus4.rd_data <= bus4.rd_en ? {4'h0, bus4.rd_addr} : (24'hA50000 | 24'($urandom_range(1, 65535)));
  end

  rec_t exp_r [2][MAXC];
  rec_t obs_r [2][MAXC];
  rec_t snap  [2];
  int   hbv   [2] = '{0, 4};
  int   ncyc;
  int   checks = 0;
  int   fails  = 0;

  function automatic rec_t sample(input int d, input bit raw);
    rec_t r;
    if (d == 0) begin
      r.ready = bus0.out_pixel_ready; r.en = bus0.rd_en; r.addr = bus0.rd_addr;
      r.valid = bus0.out_pixel_valid; r.le = bus0.out_line_end;
      r.data = bus0.out_pixel_data; r.done = bus0.frame_done; r.busy = bus0.busy;
    end else begin
      r.ready = bus4.out_pixel_ready; r.en = bus4.rd_en; r.addr = bus4.rd_addr;
      r.valid = bus4.out_pixel_valid; r.le = bus4.out_line_end;
      r.data = bus4.out_pixel_data; r.done = bus4.frame_done; r.busy = bus4.busy;
    end
    if (!raw && r.en !== 1'b1) r.addr = '0;
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("rdy=%b en=%b addr=%0d v=%b le=%b data=%0d done=%b busy=%b",
                     r.ready, r.en, r.addr, r.valid, r.le, r.data, r.done, r.busy);
  endfunction

  function automatic int flen(input int hb, input int w, input int h, input int m);
    int wo, ho;
    if (w == 0 || h == 0) return 1;
    wo = (m % 2) ? h : w;
    ho = (m % 2) ? w : h;
    return wo * ho + (ho - 1) * hb + 2;
  endfunction

  // Reference: enumerate the rotated raster and place each event on its cycle
  task automatic build_model(input int d, input int hb, input int w, input int h, input int m);
    int wo, ho, c, a;
    for (int k = 0; k < MAXC; k++) exp_r[d][k] = '0;
    if (w == 0 || h == 0) begin
      exp_r[d][1].done = 1'b1;
      exp_r[d][1].busy = 1'b1;
      return;
    end
    wo = (m % 2) ? h : w;
    ho = (m % 2) ? w : h;
    exp_r[d][1].ready = 1'b1;
    c = 1;
    for (int y = 0; y < ho; y++) begin
      for (int x = 0; x < wo; x++) begin
        case (m)
          0:       a = y * w + x;
          1:       a = (h - 1 - x) * w + y;
          2:       a = (h - 1 - y) * w + (w - 1 - x);
          default: a = x * w + (w - 1 - y);
        endcase
        exp_r[d][c].en       = 1'b1;
        exp_r[d][c].addr     = AW'(a);
        exp_r[d][c+1].valid  = 1'b1;
        exp_r[d][c+1].data   = 24'(AW'(a));
        exp_r[d][c+1].le     = (x == wo - 1);
        c++;
        if (x == wo - 1 && y < ho - 1) c += hb;
      end
    end
    exp_r[d][c+1].done = 1'b1;
    for (int k = 1; k <= c + 1; k++) exp_r[d][k].busy = 1'b1;
  endtask

  task automatic run_frame(input int w, input int h, input int m,
                           input logic [MAXC-1:0] inj0, input logic [MAXC-1:0] inj4,
                           input int rst_at);
    int l0, l4;
    build_model(0, hbv[0], w, h, m);
    build_model(1, hbv[1], w, h, m);
    l0 = flen(hbv[0], w, h, m);
    l4 = flen(hbv[1], w, h, m);
    ncyc = ((l0 > l4) ? l0 : l4) + 2;
    if (rst_at > 0)
      for (int d = 0; d < 2; d++)
        for (int k = rst_at + 1; k < MAXC; k++) exp_r[d][k] = '0;
    @(negedge clk);
    bus0.src_width = DIM_W'(w); bus0.src_height = DIM_W'(h); bus0.rot_mode = 2'(m);
    bus4.src_width = DIM_W'(w); bus4.src_height = DIM_W'(h); bus4.rot_mode = 2'(m);
    bus0.frame_start = 1'b1;
    bus4.frame_start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      obs_r[0][k] = sample(0, 1'b0);
      obs_r[1][k] = sample(1, 1'b0);
      bus0.frame_start = inj0[k];
      bus4.frame_start = inj4[k];
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        snap[0] = sample(0, 1'b1);
        snap[1] = sample(1, 1'b1);
      end
    end
    bus0.frame_start = 1'b0;
    bus4.frame_start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rec_t r;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      r = sample(d, 1'b1);
      checks++;
      if (r !== '0) begin
        fails++;
        $display("FAIL reset_state hb%0d: got %s, expected all zero", hbv[d], fmt(r));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      r = sample(d, 1'b1);
      checks++;
      if (r !== '0) begin
        fails++;
        $display("FAIL idle_after_reset hb%0d: got %s, expected all zero", hbv[d], fmt(r));
      end
    end
  endtask

  task automatic test_mode0_noblank;
    int q[$];
    run_frame(4, 2, 0, '0, '0, 0);
    for (int d = 0; d < 2; d++)
      for (int k = 1; k <= ncyc; k++) begin
        checks++;
        if (obs_r[d][k] !== exp_r[d][k]) begin
          fails++;
          $display("FAIL mode0 hb%0d cycle %0d: got %s, expected %s",
                   hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
        end
      end
    for (int k = 2; k <= 9; k++) if (obs_r[0][k].valid === 1'b1) q.push_back(int'(obs_r[0][k].data));
    checks++;
    if (q.size() != 8 || q[0] != 0 || q[3] != 3 || q[7] != 7 || obs_r[0][10].done !== 1'b1) begin
      fails++;
      $display("FAIL mode0_sequence: got %0d consecutive pixels, done@10=%b, expected 8 pixels 0..7 then done",
               q.size(), obs_r[0][10].done);
    end
  endtask

  task automatic test_rotations;
    int lst [3][6] = '{'{3, 0, 4, 1, 5, 2}, '{5, 4, 3, 2, 1, 0}, '{2, 5, 1, 4, 0, 3}};
    int q[$];
    bit ok;
    for (int m = 1; m <= 3; m++) begin
      run_frame(3, 2, m, '0, '0, 0);
      for (int d = 0; d < 2; d++)
        for (int k = 1; k <= ncyc; k++) begin
          checks++;
          if (obs_r[d][k] !== exp_r[d][k]) begin
            fails++;
            $display("FAIL rot_mode%0d hb%0d cycle %0d: got %s, expected %s",
                     m, hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
          end
        end
      q.delete();
      for (int k = 1; k <= ncyc; k++) if (obs_r[1][k].valid === 1'b1) q.push_back(int'(obs_r[1][k].data));
      ok = (q.size() == 6);
      if (ok) for (int i = 0; i < 6; i++) if (q[i] != lst[m-1][i]) ok = 0;
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL rot_mode%0d_order: got %0d pixels first=%0d, expected %0d %0d %0d %0d %0d %0d",
                 m, q.size(), (q.size() > 0) ? q[0] : -1, lst[m-1][0], lst[m-1][1],
                 lst[m-1][2], lst[m-1][3], lst[m-1][4], lst[m-1][5]);
      end
    end
  endtask

  task automatic test_degenerate;
    int cfg [4][3] = '{'{0, 5, 0}, '{3, 0, 1}, '{1, 1, 2}, '{1, 1, 3}};
    for (int t = 0; t < 4; t++) begin
      run_frame(cfg[t][0], cfg[t][1], cfg[t][2], '0, '0, 0);
      for (int d = 0; d < 2; d++)
        for (int k = 1; k <= ncyc; k++) begin
          checks++;
          if (obs_r[d][k] !== exp_r[d][k]) begin
            fails++;
            $display("FAIL degenerate_%0dx%0d hb%0d cycle %0d: got %s, expected %s",
                     cfg[t][0], cfg[t][1], hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
          end
        end
    end
  endtask

  task automatic test_ignored_starts;
    logic [MAXC-1:0] i0, i4;
    int m, nb;
    for (int t = 0; t < 2; t++) begin
      m  = (t == 0) ? int'($urandom_range(0, 3)) : 0;
      i0 = '0;
      i4 = '0;
      if (t == 0) begin
        i0[4] = 1'b1; i0[flen(0, 3, 3, m)] = 1'b1;
        i4[4] = 1'b1; i4[flen(4, 3, 3, m)] = 1'b1;
        run_frame(3, 3, m, i0, i4, 0);
      end else begin
        i0[1] = 1'b1;
        i4[1] = 1'b1;
        run_frame(0, 2, m, i0, i4, 0);
      end
      for (int d = 0; d < 2; d++) begin
        nb = 0;
        for (int k = 1; k <= ncyc; k++) begin
          if (obs_r[d][k].busy === 1'b1) nb++;
          checks++;
          if (obs_r[d][k] !== exp_r[d][k]) begin
            fails++;
            $display("FAIL ignored_start%0d hb%0d cycle %0d: got %s, expected %s",
                     t, hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
          end
        end
        checks++;
        if (nb != ((t == 0) ? 9 + 2 * hbv[d] + 2 : 1)) begin
          fails++;
          $display("FAIL frame_length%0d hb%0d: got %0d busy cycles, expected %0d",
                   t, hbv[d], nb, (t == 0) ? 9 + 2 * hbv[d] + 2 : 1);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int m;
    m = int'($urandom_range(0, 3));
    run_frame(4, 3, m, '0, '0, 3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (snap[d] !== '0) begin
        fails++;
        $display("FAIL reset_async hb%0d: got %s, expected all zero", hbv[d], fmt(snap[d]));
      end
      for (int k = 1; k <= ncyc; k++) begin
        checks++;
        if (obs_r[d][k] !== exp_r[d][k]) begin
          fails++;
          $display("FAIL reset_abort hb%0d cycle %0d: got %s, expected %s",
                   hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
        end
      end
    end
    run_frame(4, 3, m, '0, '0, 0);
    for (int d = 0; d < 2; d++)
      for (int k = 1; k <= ncyc; k++) begin
        checks++;
        if (obs_r[d][k] !== exp_r[d][k]) begin
          fails++;
          $display("FAIL after_reset hb%0d cycle %0d: got %s, expected %s",
                   hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
        end
      end
  endtask

  task automatic test_random_frames;
    int w, h, m;
    for (int t = 0; t < 14; t++) begin
      w = int'($urandom_range(0, 6));
      h = int'($urandom_range(0, 6));
      m = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(w, h, m, '0, '0, 0);
      for (int d = 0; d < 2; d++)
        for (int k = 1; k <= ncyc; k++) begin
          checks++;
          if (obs_r[d][k] !== exp_r[d][k]) begin
            fails++;
            $display("FAIL random_%0dx%0d_m%0d hb%0d cycle %0d: got %s, expected %s",
                     w, h, m, hbv[d], k, fmt(obs_r[d][k]), fmt(exp_r[d][k]));
          end
        end
    end
  endtask

  initial begin
    bus0.frame_start = 1'b0; bus0.src_width = '0; bus0.src_height = '0; bus0.rot_mode = '0;
    bus4.frame_start = 1'b0; bus4.src_width = '0; bus4.src_height = '0; bus4.rot_mode = '0;
    test_reset();
    test_mode0_noblank();
    test_rotations();
    test_degenerate();
    test_ignored_starts();
    test_reset_midframe();
    test_random_frames();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", checks - fails, checks);
    $fatal(1);
  end

endmodule
